// File: rtl/game_pkg.sv
// Shared game types and screen/tank constants for the bullet, tank and render blocks.
package game_pkg;

    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;
    localparam int COORD_W_DEF   = 10;
    localparam int TANK_SIZE_DEF = 32;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        HIT    = 2'd2
    } bullet_state_t;

endpackage

// File: rtl/bullet_unit_if.sv
// Bullet unit bus: controls and positions in from the game side, bullet state out.
interface bullet_unit_if #(
    parameter int COORD_W = 10
);
    import game_pkg::*;

    logic               tick_i;
    logic               fire_i;
    logic [COORD_W-1:0] shooter_x_i;
    logic [COORD_W-1:0] shooter_y_i;
    dir_t               shooter_dir_i;
    logic [COORD_W-1:0] target_x_i;
    logic [COORD_W-1:0] target_y_i;
    logic               bullet_active_o;
    logic [COORD_W-1:0] bullet_x_o;
    logic [COORD_W-1:0] bullet_y_o;
    logic               hit_o;

    modport master (
        output tick_i, fire_i, shooter_x_i, shooter_y_i, shooter_dir_i,
               target_x_i, target_y_i,
        input  bullet_active_o, bullet_x_o, bullet_y_o, hit_o
    );

    modport slave (
        input  tick_i, fire_i, shooter_x_i, shooter_y_i, shooter_dir_i,
               target_x_i, target_y_i,
        output bullet_active_o, bullet_x_o, bullet_y_o, hit_o
    );
endinterface

// File: rtl/pos_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 on level.
module pos_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic level_q;

    // Track previous level and emit a registered pulse on a rising transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/bullet_unit.sv
// Single-bullet owner for one player: spawn on fire, move on tick, retire at edge, flag hit.
module bullet_unit
    import game_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int TANK_SIZE = TANK_SIZE_DEF,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         game_reset_i,
    bullet_unit_if.slave bus
);
    localparam int EXT_W = COORD_W + 1;
    localparam int CD_W  = $clog2(COOLDOWN + 1);

    logic               clear;
    logic               fire_pulse;
    bullet_state_t      state;
    bullet_state_t      state_next;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    dir_t               dir;
    logic [CD_W-1:0]    cooldown;

    logic [EXT_W-1:0]   nx_ext;
    logic [EXT_W-1:0]   ny_ext;
    logic               off_screen;
    logic               in_target;
    logic               spawn;

    assign clear = reset_i | game_reset_i;
    assign spawn = (state == IDLE) && fire_pulse && (cooldown == '0);

    // Both resets also clear the edge detector so a press right after release counts.
    pos_edge_detect u_fire_edge (
        .clk   (clk_i),
        .rst   (clear),
        .level (bus.fire_i),
        .pulse (fire_pulse)
    );

    // Candidate next position and screen/target tests, in one extra bit so nothing wraps.
    always_comb begin
        nx_ext     = {1'b0, pos_x};
        ny_ext     = {1'b0, pos_y};
        off_screen = 1'b0;
        case (dir)
            UP: begin
                off_screen = {1'b0, pos_y} < EXT_W'(SPEED);
                ny_ext     = {1'b0, pos_y} - EXT_W'(SPEED);
            end
            DOWN: begin
                ny_ext     = {1'b0, pos_y} + EXT_W'(SPEED);
                off_screen = ny_ext > EXT_W'(SCREEN_H - 1);
            end
            LEFT: begin
                off_screen = {1'b0, pos_x} < EXT_W'(SPEED);
                nx_ext     = {1'b0, pos_x} - EXT_W'(SPEED);
            end
            default: begin
                nx_ext     = {1'b0, pos_x} + EXT_W'(SPEED);
                off_screen = nx_ext > EXT_W'(SCREEN_W - 1);
            end
        endcase
        in_target = (nx_ext >= {1'b0, bus.target_x_i}) &&
                    (nx_ext <= {1'b0, bus.target_x_i} + EXT_W'(TANK_SIZE - 1)) &&
                    (ny_ext >= {1'b0, bus.target_y_i}) &&
                    (ny_ext <= {1'b0, bus.target_y_i} + EXT_W'(TANK_SIZE - 1));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: spawn from IDLE, retire or hit on a moving tick, HIT holds until reset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (spawn) state_next = FLYING;
            FLYING: begin
                if (bus.tick_i) begin
                    if (off_screen)     state_next = IDLE;
                    else if (in_target) state_next = HIT;
                end
            end
            HIT:     state_next = HIT;
            default: state_next = IDLE;
        endcase
    end

    // Position, latched direction and cooldown; a tick on the spawn cycle does not move.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            pos_x    <= '0;
            pos_y    <= '0;
            dir      <= UP;
            cooldown <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawn) begin
                        pos_x <= bus.shooter_x_i + COORD_W'(TANK_SIZE / 2);
                        pos_y <= bus.shooter_y_i + COORD_W'(TANK_SIZE / 2);
                        dir   <= bus.shooter_dir_i;
                    end else if (bus.tick_i && cooldown != '0) begin
                        cooldown <= cooldown - 1'b1;
                    end
                end
                FLYING: begin
                    if (bus.tick_i) begin
                        if (off_screen) begin
                            cooldown <= CD_W'(COOLDOWN);
                        end else begin
                            pos_x <= nx_ext[COORD_W-1:0];
                            pos_y <= ny_ext[COORD_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the registered state.
    always_comb begin
        bus.bullet_active_o = (state == FLYING);
        bus.hit_o           = (state == HIT);
        bus.bullet_x_o      = pos_x;
        bus.bullet_y_o      = pos_y;
    end
endmodule

// File: tb/tb_bullet_unit.sv
// Directed bench for bullet_unit: hit, edge exits, cooldown, held fire, round reset.
module tb_bullet_unit;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset_i;
    logic game_reset_i;
    int   total = 0;
    int   bad   = 0;

    bullet_unit_if #(.COORD_W(10)) bus ();

    bullet_unit dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .game_reset_i (game_reset_i),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        bus.tick_i = 1'b1;
        cyc(1);
        bus.tick_i = 1'b0;
    endtask

    // Press and release: spawn (if accepted) is visible when this returns.
    task automatic press();
        bus.fire_i = 1'b1;
        cyc(2);
        bus.fire_i = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc(2);
        reset_i = 1'b0;
    endtask

    task automatic shooter(input int x, input int y, input dir_t d);
        bus.shooter_x_i   = 10'(x);
        bus.shooter_y_i   = 10'(y);
        bus.shooter_dir_i = d;
    endtask

    initial begin
        reset_i          = 1'b1;
        game_reset_i     = 1'b0;
        bus.tick_i       = 1'b0;
        bus.fire_i       = 1'b0;
        shooter(0, 0, UP);
        bus.target_x_i   = 10'd600;
        bus.target_y_i   = 10'd0;
        cyc(2);
        reset_i = 1'b0;

        // Reset state
        chk("rst_active", int'(bus.bullet_active_o), 0);
        chk("rst_hit", int'(bus.hit_o), 0);
        chk("rst_x", int'(bus.bullet_x_o), 0);
        chk("rst_y", int'(bus.bullet_y_o), 0);

        // Right-hit: spawn one cycle after the pulse, hit on tick 21
        shooter(100, 100, RIGHT);
        bus.target_x_i = 10'd200;
        bus.target_y_i = 10'd100;
        bus.fire_i = 1'b1;
        cyc(1);
        chk("rh_pulse_only", int'(bus.bullet_active_o), 0);
        cyc(1);
        bus.fire_i = 1'b0;
        chk("rh_spawn_active", int'(bus.bullet_active_o), 1);
        chk("rh_spawn_x", int'(bus.bullet_x_o), 116);
        chk("rh_spawn_y", int'(bus.bullet_y_o), 116);
        shooter(100, 100, UP);  // must not redirect the bullet
        cyc(3);
        chk("rh_hold_x", int'(bus.bullet_x_o), 116);
        tick1();
        chk("rh_t1_x", int'(bus.bullet_x_o), 120);
        repeat (19) tick1();
        chk("rh_t20_x", int'(bus.bullet_x_o), 196);
        chk("rh_t20_hit", int'(bus.hit_o), 0);
        tick1();
        chk("rh_t21_hit", int'(bus.hit_o), 1);
        chk("rh_t21_active", int'(bus.bullet_active_o), 0);
        chk("rh_t21_x", int'(bus.bullet_x_o), 200);
        chk("rh_t21_y", int'(bus.bullet_y_o), 116);
        press();
        tick1();
        chk("rh_hold_hit", int'(bus.hit_o), 1);
        chk("rh_hold_inactive", int'(bus.bullet_active_o), 0);

        // Round reset in HIT, then immediate fire spawns
        game_reset_i = 1'b1;
        cyc(1);
        game_reset_i = 1'b0;
        chk("gr_hit_hit", int'(bus.hit_o), 0);
        chk("gr_hit_active", int'(bus.bullet_active_o), 0);
        press();
        chk("gr_hit_respawn", int'(bus.bullet_active_o), 1);

        // Round reset in FLYING, then immediate fire spawns
        game_reset_i = 1'b1;
        cyc(1);
        game_reset_i = 1'b0;
        chk("gr_fly_active", int'(bus.bullet_active_o), 0);
        chk("gr_fly_x", int'(bus.bullet_x_o), 0);
        press();
        chk("gr_fly_respawn", int'(bus.bullet_active_o), 1);
        do_reset();

        // Left-exit with cooldown
        shooter(0, 200, LEFT);
        bus.target_x_i = 10'd600;
        bus.target_y_i = 10'd0;
        press();
        chk("le_spawn_x", int'(bus.bullet_x_o), 16);
        chk("le_spawn_y", int'(bus.bullet_y_o), 216);
        for (int k = 1; k <= 4; k++) begin
            tick1();
            chk("le_step_x", int'(bus.bullet_x_o), 16 - 4 * k);
        end
        chk("le_x0_active", int'(bus.bullet_active_o), 1);
        tick1();
        chk("le_retire_active", int'(bus.bullet_active_o), 0);
        chk("le_retire_hit", int'(bus.hit_o), 0);
        chk("le_retire_x", int'(bus.bullet_x_o), 0);
        repeat (3) tick1();
        press();
        chk("le_cooldown_drop", int'(bus.bullet_active_o), 0);
        repeat (5) tick1();
        press();
        chk("le_after_cd_spawn", int'(bus.bullet_active_o), 1);
        chk("le_after_cd_x", int'(bus.bullet_x_o), 16);
        do_reset();

        // Down-exit
        shooter(300, 448, DOWN);
        press();
        chk("de_spawn_y", int'(bus.bullet_y_o), 464);
        chk("de_spawn_x", int'(bus.bullet_x_o), 316);
        for (int k = 1; k <= 3; k++) begin
            tick1();
            chk("de_step_y", int'(bus.bullet_y_o), 464 + 4 * k);
        end
        tick1();
        chk("de_retire_active", int'(bus.bullet_active_o), 0);
        chk("de_retire_y", int'(bus.bullet_y_o), 476);
        do_reset();

        // Held fire: one spawn, second press in flight changes nothing
        shooter(50, 60, DOWN);
        bus.fire_i = 1'b1;
        cyc(50);
        bus.fire_i = 1'b0;
        chk("hf_active", int'(bus.bullet_active_o), 1);
        chk("hf_x", int'(bus.bullet_x_o), 66);
        chk("hf_y", int'(bus.bullet_y_o), 76);
        shooter(400, 300, UP);
        press();
        chk("hf_refire_x", int'(bus.bullet_x_o), 66);
        chk("hf_refire_y", int'(bus.bullet_y_o), 76);
        tick1();
        chk("hf_move_y", int'(bus.bullet_y_o), 80);
        do_reset();

        // Simultaneous fire pulse and tick in IDLE
        shooter(200, 200, UP);
        bus.fire_i = 1'b1;
        cyc(1);
        bus.tick_i = 1'b1;
        cyc(1);
        bus.tick_i = 1'b0;
        bus.fire_i = 1'b0;
        chk("sim_active", int'(bus.bullet_active_o), 1);
        chk("sim_y", int'(bus.bullet_y_o), 216);
        tick1();
        chk("sim_move_y", int'(bus.bullet_y_o), 212);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bullet_unit.md
Name: bullet_unit

Overview:
- Owns the single in-flight bullet of one player: spawns it on a fire key press, advances it once per frame tick, and retires it at the screen edge.
- Detects overlap with the opposing tank and raises the collision level consumed by the game FSM (bullet_collide_player_N_i). Instantiate twice, one per player.
- Cleared by the FSM's round reset, so no bullet survives into MENU or CONTINUE.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- COORD_W, 10, coordinate width in bits.
- TANK_SIZE, 32, tank bounding-box side in pixels.
- SPEED, 4, pixels moved per tick.
- COOLDOWN, 8, ticks after bullet retirement before the next fire is accepted.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- game_reset_i  in  1  FSM reset_o; synchronous clear, same effect as reset_i.
- tick_i  in  1  one-cycle frame pulse; all motion and cooldown advance on it.
- fire_i  in  1  fire key level.
- shooter_x_i, shooter_y_i  in  COORD_W  top-left of the owning tank.
- shooter_dir_i  in  2  facing direction (dir_t).
- target_x_i, target_y_i  in  COORD_W  top-left of the opposing tank.
- bullet_active_o  out  1  bullet visible/in flight.
- bullet_x_o, bullet_y_o  out  COORD_W  bullet position.
- hit_o  out  1  collision level to the FSM.

Behaviour:
- Reset values (reset_i or game_reset_i): state IDLE, bullet_active_o=0, bullet_x_o=bullet_y_o=0, hit_o=0, cooldown=0, stored direction=UP. Either reset overrides all other inputs in that cycle.
- Fire detect: fire_i goes through a rising-edge detector, giving a one-cycle fire pulse one cycle after the 0->1 transition. Holding fire_i yields one pulse only.
- IDLE:
  - fire pulse with cooldown==0 -> FLYING.
  - Position latches the shooter centre: (shooter_x_i+TANK_SIZE/2, shooter_y_i+TANK_SIZE/2). shooter_dir_i is latched at the same time.
  - bullet_active_o=1 at the next edge.
  - A fire pulse with cooldown>0 is dropped, not queued.
  - Each tick_i with cooldown>0 decrements it.
  - A tick in the same cycle as the spawn does not move the bullet.
- FLYING, on tick_i: compute the next position from the latched direction.
  - UP: y-SPEED. DOWN: y+SPEED. LEFT: x-SPEED. RIGHT: x+SPEED.
  - Off-screen when UP and y<SPEED, LEFT and x<SPEED, DOWN and y+SPEED>SCREEN_H-1, or RIGHT and x+SPEED>SCREEN_W-1. Compare with one extra bit of width; no wrap-around.
  - Off-screen -> IDLE, bullet_active_o=0, cooldown=COOLDOWN, position unchanged.
  - Otherwise store the next position. If it lies inside [target_x, target_x+TANK_SIZE-1] x [target_y, target_y+TANK_SIZE-1] (inclusive) -> HIT.
  - No tick: hold.
  - Fire pulses in FLYING are ignored. Shooter direction changes after spawn do not affect the bullet.
- HIT:
  - hit_o=1 and bullet_active_o=0 from the same edge that enters HIT. Position holds the collision point.
  - hit_o stays high, and fire is ignored, until reset_i or game_reset_i.
  - The FSM edge-detects hit_o, so a held level is correct.
- Latency: hit_o rises at the clock edge that samples the colliding tick_i (0 extra cycles).
- The shooter's own box is never tested. Target position is sampled only on the moving tick.

Decomposition:
- game_pkg holds:
  - typedef dir_t (UP=0, RIGHT=1, DOWN=2, LEFT=3);
  - typedef bullet_state_t (IDLE, FLYING, HIT);
  - screen and tank-size constants shared with the tank and render blocks.
- Sub-module: reuse the existing pos_edge_detect for fire_i. The motion/collision logic stays inline.

Test Plan:
- Right-hit: shooter (100,100) RIGHT, target (200,100), fire, 21 ticks.
  - Spawn at (116,116); x=116+4n.
  - hit_o rises on tick 21 with x=200; bullet_active_o falls the same edge.
- Left-exit: shooter (0,200) LEFT.
  - Spawn x=16; ticks give x = 12, 8, 4, 0.
  - 5th tick retires the bullet, hit_o stays 0.
  - A fire press after 3 more ticks is ignored; a fire after 8 ticks spawns.
- Down-exit: shooter (300,448) DOWN.
  - Spawn y=464; ticks give y = 468, 472, 476.
  - 4th tick retires the bullet (480>479).
- Held fire: fire_i high for 50 cycles with no ticks -> exactly one spawn; a second press during FLYING changes nothing.
- Round reset: game_reset_i pulsed in FLYING and again in HIT.
  - Next edge: bullet_active_o=0, hit_o=0, cooldown=0.
  - An immediate fire after release spawns.
- Simultaneous: fire pulse and tick_i in the same cycle in IDLE -> spawn at centre with no movement; movement starts on the next tick.
